// File: rtl/cd_rx_pkg.sv
// Shared encodings and sizes for the CDBUS receive frame buffer.
// No logic; imported by the buffer and its tests.
package cd_rx_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_SKIP = 2'd2
    } wstate_e;

    localparam int PAGE_BYTES = 256;
    localparam int LEN_W      = 9;

endpackage

// File: rtl/cd_sdpram.sv
// Simple dual-port word RAM, one clock, active-low chip and write enables.
// Registered read (1 cycle), read-before-write on address collision; no backpressure.
module cd_sdpram #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               cen,
    input  logic               wen,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [1 << A_WIDTH];
    logic [D_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[waddr] <= wdata;
            end
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cd_rx_ram.sv
// Paged RX frame buffer: byte-wise frame fill into the tail page, 32-bit host reads from the head page.
// Read data 1 cycle after rd_en; writes never stall, frames arriving while full are skipped and counted.
module cd_rx_ram
    import cd_rx_pkg::*;
#(
    parameter int PAGE_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           wr_byte,
    input  logic [7:0]           wr_addr,
    input  logic                 wr_en,
    input  logic                 wr_done,
    input  logic                 wr_drop,
    output logic                 wr_full,
    input  logic [5:0]           rd_addr,
    input  logic                 rd_en,
    output logic [31:0]          rd_word,
    output logic [LEN_W-1:0]     rd_len,
    input  logic                 rd_done,
    output logic                 unread,
    output logic [PAGE_BITS:0]   pend_cnt,
    output logic [7:0]           lost_cnt
);

    localparam int PAGES = 1 << PAGE_BITS;
    localparam int AW    = PAGE_BITS + 6;
    localparam logic [PAGE_BITS:0] FULL_CNT = (PAGE_BITS + 1)'(PAGES);

    wstate_e                state_q, state_d;
    logic [PAGE_BITS-1:0]   head_q, head_d;
    logic [PAGE_BITS-1:0]   tail_q, tail_d;
    logic [PAGE_BITS:0]     pend_q, pend_d;
    logic [7:0]             lost_q, lost_d;
    logic [23:0]            pack_q, pack_d;
    logic [LEN_W-1:0]       wlen_q, wlen_d;
    logic [LEN_W-1:0]       len_q [PAGES];
    logic [LEN_W-1:0]       len_d [PAGES];

    logic                   full;
    logic                   byte_acc;
    logic                   commit;
    logic                   release_pg;
    logic                   word_wr;
    logic [5:0]             flush_word;
    logic [AW-1:0]          waddr;
    logic [31:0]            wdata;

    assign full = (pend_q == FULL_CNT);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pend_d     = pend_q;
        lost_d     = lost_q;
        pack_d     = pack_q;
        wlen_d     = wlen_q;
        len_d      = len_q;
        byte_acc   = 1'b0;
        commit     = 1'b0;
        release_pg = rd_done && (pend_q != '0);

        // Drop beats done beats a byte; a byte alongside either is discarded.
        case (state_q)
            W_IDLE: begin
                if (wr_en && !wr_done && !wr_drop) begin
                    if (full) begin
                        state_d = W_SKIP;
                    end else begin
                        state_d  = W_FILL;
                        byte_acc = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (wr_drop) begin
                    state_d = W_IDLE;
                end else if (wr_done) begin
                    state_d = W_IDLE;
                    commit  = 1'b1;
                end else if (wr_en) begin
                    byte_acc = 1'b1;
                end
            end
            W_SKIP: begin
                if (wr_drop) begin
                    state_d = W_IDLE;
                end else if (wr_done) begin
                    state_d = W_IDLE;
                    if (lost_q != 8'hff) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase

        if (byte_acc) begin
            case (wr_addr[1:0])
                2'd0:    pack_d[7:0]   = wr_byte;
                2'd1:    pack_d[15:8]  = wr_byte;
                2'd2:    pack_d[23:16] = wr_byte;
                default: pack_d        = pack_q;
            endcase
            wlen_d = {1'b0, wr_addr} + 9'd1;
        end

        // Lane 3 completes a word directly; a commit flushes any partial word still in pack.
        flush_word = 6'((wlen_q - 9'd1) >> 2);
        word_wr    = (byte_acc && (wr_addr[1:0] == 2'd3)) ||
                     (commit && (wlen_q[1:0] != 2'd0));
        if (byte_acc) begin
            waddr = {tail_q, wr_addr[7:2]};
            wdata = {wr_byte, pack_q};
        end else begin
            waddr = {tail_q, flush_word};
            wdata = {8'h00, pack_q};
        end

        if (commit) begin
            len_d[tail_q] = wlen_q;
            tail_d        = tail_q + 1'b1;
        end
        if (release_pg) begin
            head_d = head_q + 1'b1;
        end
        case ({commit, release_pg})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= W_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            pend_q  <= '0;
            lost_q  <= '0;
            pack_q  <= '0;
            wlen_q  <= '0;
            for (int i = 0; i < PAGES; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            pack_q  <= pack_d;
            wlen_q  <= wlen_d;
            for (int i = 0; i < PAGES; i++) begin
                len_q[i] <= len_d[i];
            end
        end
    end

    cd_sdpram #(
        .A_WIDTH (AW),
        .D_WIDTH (32)
    ) u_ram (
        .clk   (clk),
        .cen   (!(rd_en || word_wr)),
        .wen   (!word_wr),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({head_q, rd_addr}),
        .rdata (rd_word)
    );

    assign wr_full  = full;
    assign unread   = (pend_q != '0);
    assign pend_cnt = pend_q;
    assign lost_cnt = lost_q;
    assign rd_len   = len_q[head_q];

endmodule

// File: tb/tb_cd_rx_ram.sv
// Self-checking bench for cd_rx_ram: frame commit/drop, full and skip counting, wrap, overlap, reset.
module tb_cd_rx_ram;

    localparam int PB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    wr_byte;
    logic [7:0]    wr_addr;
    logic          wr_en;
    logic          wr_done;
    logic          wr_drop;
    logic          wr_full;
    logic [5:0]    rd_addr;
    logic          rd_en;
    logic [31:0]   rd_word;
    logic [8:0]    rd_len;
    logic          rd_done;
    logic          unread;
    logic [PB:0]   pend_cnt;
    logic [7:0]    lost_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] dat;
        logic [31:0] msk;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int          len;
        logic [7:0]  base;
        logic [8:0]  exp_len;
    } vec_t;
    vec_t vt[10];

    always #5 clk = ~clk;

    cd_rx_ram #(.PAGE_BITS(PB)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_byte  (wr_byte),
        .wr_addr  (wr_addr),
        .wr_en    (wr_en),
        .wr_done  (wr_done),
        .wr_drop  (wr_drop),
        .wr_full  (wr_full),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_word  (rd_word),
        .rd_len   (rd_len),
        .rd_done  (rd_done),
        .unread   (unread),
        .pend_cnt (pend_cnt),
        .lost_cnt (lost_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [7:0] base, input logic [7:0] step, input int i);
        return base + 8'(i) * step;
    endfunction

    // term: 0 = leave open, 1 = wr_done, 2 = wr_drop
    task automatic write_frame(input int len, input logic [7:0] base, input logic [7:0] step, input int term);
        for (int i = 0; i < len; i++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_byte = fbyte(base, step, i);
            tick();
        end
        wr_en = 1'b0;
        if (term != 0) begin
            wr_done = (term == 1);
            wr_drop = (term == 2);
            tick();
            wr_done = 1'b0;
            wr_drop = 1'b0;
        end
    endtask

    task automatic read_check(input int w, input int len, input logic [7:0] base, input logic [7:0] step);
        exp_t e;
        exp_t got;
        e.dat = '0;
        e.msk = '0;
        for (int b = 0; b < 4; b++) begin
            if (4 * w + b < len) begin
                e.dat[8*b +: 8] = fbyte(base, step, 4 * w + b);
                e.msk[8*b +: 8] = 8'hff;
            end
        end
        sb_q.push_back(e);
        rd_en   = 1'b1;
        rd_addr = 6'(w);
        tick();
        rd_en = 1'b0;
        got = sb_q.pop_front();
        check($sformatf("rd_word[%0d]", w), rd_word & got.msk, got.dat);
    endtask

    task automatic read_frame(input int len, input logic [7:0] base, input logic [7:0] step);
        check("rd_len", 32'(rd_len), 32'(len));
        for (int w = 0; w < (len + 3) / 4; w++) begin
            read_check(w, len, base, step);
        end
    endtask

    task automatic release_page();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            vt[i] = '{i + 1, 8'(16 * i + 1), 9'(i + 1)};
        end

        reset   = 1'b1;
        wr_byte = '0;
        wr_addr = '0;
        wr_en   = 1'b0;
        wr_done = 1'b0;
        wr_drop = 1'b0;
        rd_addr = '0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("reset wr_full", 32'(wr_full), 0);
        check("reset unread", 32'(unread), 0);
        check("reset rd_len", 32'(rd_len), 0);
        check("reset pend_cnt", 32'(pend_cnt), 0);
        check("reset lost_cnt", 32'(lost_cnt), 0);

        // Empty release and idle commit are both no-ops.
        release_page();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check("idle ops pend_cnt", 32'(pend_cnt), 0);

        // Basic frame
        write_frame(5, 8'h11, 8'h11, 1);
        check("basic unread", 32'(unread), 1);
        read_frame(5, 8'h11, 8'h11);
        release_page();
        check("basic released", 32'(pend_cnt), 0);

        // Drop then commit into the reused page
        write_frame(3, 8'h70, 8'h01, 2);
        check("drop pend_cnt", 32'(pend_cnt), 0);
        write_frame(4, 8'hA0, 8'h01, 1);
        check("drop-commit pend_cnt", 32'(pend_cnt), 1);
        read_frame(4, 8'hA0, 8'h01);
        release_page();

        // Full and lost count
        for (int f = 0; f < 4; f++) begin
            write_frame(6, 8'(8'h30 + 8'(f)), 8'h01, 1);
        end
        check("full wr_full", 32'(wr_full), 1);
        check("full pend_cnt", 32'(pend_cnt), 4);
        write_frame(5, 8'hEE, 8'h01, 1);
        check("full 5th pend_cnt", 32'(pend_cnt), 4);
        check("full lost_cnt", 32'(lost_cnt), 1);
        read_frame(6, 8'h30, 8'h01);
        release_page();
        check("after release wr_full", 32'(wr_full), 0);
        check("after release pend_cnt", 32'(pend_cnt), 3);
        for (int f = 1; f < 4; f++) begin
            read_frame(6, 8'(8'h30 + 8'(f)), 8'h01);
            release_page();
        end
        check("full drained", 32'(pend_cnt), 0);

        // Wrap: table of frame lengths 1..10
        for (int i = 0; i < 10; i++) begin
            write_frame(vt[i].len, vt[i].base, 8'h03, 1);
            check($sformatf("wrap%0d unread", i), 32'(unread), 1);
            check($sformatf("wrap%0d rd_len", i), 32'(rd_len), 32'(vt[i].exp_len));
            read_frame(vt[i].len, vt[i].base, 8'h03);
            release_page();
        end
        check("wrap drained", 32'(pend_cnt), 0);

        // Simultaneous commit and release
        write_frame(3, 8'h50, 8'h01, 1);
        write_frame(5, 8'h60, 8'h01, 1);
        check("sim pre pend_cnt", 32'(pend_cnt), 2);
        write_frame(8, 8'hC0, 8'h01, 0);
        wr_done = 1'b1;
        rd_done = 1'b1;
        tick();
        wr_done = 1'b0;
        rd_done = 1'b0;
        check("sim pend_cnt", 32'(pend_cnt), 2);
        read_frame(5, 8'h60, 8'h01);
        release_page();
        read_frame(8, 8'hC0, 8'h01);
        release_page();
        check("sim drained", 32'(pend_cnt), 0);

        // Reset mid-frame with state outstanding
        write_frame(7, 8'h20, 8'h01, 1);
        write_frame(2, 8'h90, 8'h01, 0);
        wr_en   = 1'b1;
        wr_addr = 8'd2;
        wr_byte = 8'h92;
        #2;
        reset = 1'b1;
        #1;
        check("midreset pend_cnt", 32'(pend_cnt), 0);
        check("midreset unread", 32'(unread), 0);
        check("midreset rd_len", 32'(rd_len), 0);
        check("midreset lost_cnt", 32'(lost_cnt), 0);
        wr_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        write_frame(4, 8'hB0, 8'h01, 1);
        check("post-reset pend_cnt", 32'(pend_cnt), 1);
        read_frame(4, 8'hB0, 8'h01);

        // Saturation: fill, then 300 skipped frames
        for (int f = 0; f < 3; f++) begin
            write_frame(2, 8'h01, 8'h01, 1);
        end
        check("sat full", 32'(wr_full), 1);
        for (int f = 0; f < 300; f++) begin
            write_frame(1, 8'hFF, 8'h01, 1);
        end
        check("sat lost_cnt", 32'(lost_cnt), 255);
        check("sat pend_cnt", 32'(pend_cnt), 4);
        check("sb empty", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
